// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS program-counter sequencer with branch/jump/jr target formation,
// a single-entry pending-redirect buffer and a valid/ready fetch request.
// Optional feature macro PC_ALIGN_CHECK_EN: drop misaligned targets and flag misalign_err.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_ready,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        redirect_pending,
    output logic        halted,
    output logic        misalign_err
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pend_pc_q, pend_pc_d, raw_tgt, tgt;
    logic        pend_q, pend_d, fv_q, fv_d, halted_q, halted_d;
    logic        accept, live, redir_ok;
`ifdef PC_ALIGN_CHECK_EN
    logic        err_q, err_d;
`endif
    assign pc               = pc_q;
    assign pc_plus4         = pc_q + 32'd4;
    assign fetch_valid      = fv_q;
    assign redirect_pending = pend_q;
    assign halted           = halted_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err     = err_q;
`else
    assign misalign_err     = 1'b0;
`endif
    // Select the winning redirect, then decide next PC, pending buffer and state.
    always_comb begin
        accept   = fv_q & fetch_ready & ~stall;
        live     = fv_q & (jr | jump | branch_taken);
        raw_tgt  = jr ? jr_target : jump ? {pc_q[31:28], jump_index, 2'b00} : pc_q + branch_offset;
`ifdef PC_ALIGN_CHECK_EN
        tgt      = raw_tgt;
        redir_ok = live & ~|raw_tgt[1:0];
        err_d    = err_q | (live & |raw_tgt[1:0]);
`else
        tgt      = raw_tgt & ~32'd3;
        redir_ok = live;
`endif
        pc_d      = accept ? (redir_ok ? tgt : pend_q ? pend_pc_q : pc_plus4) : pc_q;
        pend_d    = ~accept & (redir_ok | pend_q);
        pend_pc_d = (~accept & redir_ok) ? tgt : pend_pc_q;
        state_d   = state_q == BOOT ? RUN : (state_q == RUN && halt) ? HALTED : state_q;
        fv_d      = state_d == RUN;
        halted_d  = state_d == HALTED;
    end
    // Register state, PC, pending redirect and the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            fv_q      <= 1'b0;
            halted_q  <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            fv_q      <= fv_d;
            halted_q  <= halted_d;
`ifdef PC_ALIGN_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer; directed plan cases plus random traffic.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_ready = 1'b0, stall = 1'b0, halt = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
    logic [31:0] branch_offset = '0, jr_target = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, redirect_pending, halted, misalign_err;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .jump_index(jump_index), .jr(jr), .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .redirect_pending(redirect_pending), .halted(halted),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pend, fv, hl, err;
    } exp_t;
    exp_t q[$];

    int tests = 0, fails = 0;

    // Reference model: mode 0=boot, 1=run, 2=halted.
    int          m_mode = 0;
    logic [31:0] m_pc = 32'h0040_0000, m_pend_pc = '0;
    logic        m_pend = 1'b0, m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0040_0000; m_pend = 1'b0; m_err = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the post-edge state, queue it, then move to next negedge.
    task automatic cyc(input logic rdy, input logic stl, input logic hlt, input logic br,
                       input logic [31:0] off, input logic j, input logic [25:0] idx,
                       input logic r, input logic [31:0] rt);
        logic        acc, live, ok;
        logic [31:0] t;
        exp_t        e;
        fetch_ready = rdy; stall = stl; halt = hlt; branch_taken = br; branch_offset = off;
        jump = j; jump_index = idx; jr = r; jr_target = rt;
        acc  = (m_mode == 1) && rdy && !stl;
        live = (m_mode == 1) && (r || j || br);
        if (r) t = rt;
        else if (j) t = {m_pc[31:28], idx, 2'b00};
        else t = m_pc + off;
`ifdef PC_ALIGN_CHECK_EN
        ok = live && (t[1:0] == 2'b00);
        if (live && !ok) m_err = 1'b1;
`else
        ok = live;
        t[1:0] = 2'b00;
`endif
        if (acc) begin
            m_pc = ok ? t : m_pend ? m_pend_pc : m_pc + 32'd4;
            m_pend = 1'b0;
        end else if (ok) begin
            m_pend = 1'b1;
            m_pend_pc = t;
        end
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && hlt) m_mode = 2;
        e.pc = m_pc; e.pend = m_pend; e.fv = (m_mode == 1); e.hl = (m_mode == 2); e.err = m_err;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cyc(rdy, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 32'h0040_0000);
        chk({tag, "_fv"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_pend"}, {31'd0, redirect_pending}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_err"}, {31'd0, misalign_err}, 32'd0);
    endtask

    // Monitor: after every active edge, pop the predicted state and compare.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
            chk("sb_fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
            chk("sb_redirect_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
            chk("sb_halted", {31'd0, halted}, {31'd0, e.hl});
            chk("sb_misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        model_reset();
        // Free run: 0x400000 (fv rises), 0x400004, 0x400008, 0x40000C, 0x400010.
        idle(1'b1);
        chk("boot_first_fv", {31'd0, fetch_valid}, 32'd1);
        chk("boot_first_pc", pc, 32'h0040_0000);
        idle(1'b1);
        chk("run_pc4", pc, 32'h0040_0004);
        idle(1'b1);
        chk("run_pc8", pc, 32'h0040_0008);
        idle(1'b1);
        idle(1'b1);
        chk("run_pc10", pc, 32'h0040_0010);
        // Backward branch.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'd0, 1'b0, 32'd0);
        chk("branch_back", pc, 32'h0040_0000);
        // Jump held off by fetch_ready=0 for 3 cycles, then accepted from the pending buffer.
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h0100020, 1'b0, 32'd0);
        chk("jump_pending", {31'd0, redirect_pending}, 32'd1);
        chk("jump_pc_hold", pc, 32'h0040_0000);
        idle(1'b1);
        chk("jump_taken", pc, 32'h0040_0080);
        chk("jump_pend_clr", {31'd0, redirect_pending}, 32'd0);
        // Stall blocks acceptance too.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        chk("stall_hold", pc, 32'h0040_0080);
        // jr beats branch.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'd0, 1'b1, 32'h0040_1000);
        chk("jr_over_branch", pc, 32'h0040_1000);
        // jr beats jump.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h0000001, 1'b1, 32'hFFFF_FFFC);
        chk("jr_over_jump", pc, 32'hFFFF_FFFC);
        // Wrap-around of sequential PC.
        idle(1'b1);
        chk("wrap", pc, 32'h0000_0000);
`ifdef PC_ALIGN_CHECK_EN
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0040_0002);
        chk("misalign_drop", pc, 32'h0000_0004);
        chk("misalign_flag", {31'd0, misalign_err}, 32'd1);
`endif
        // Randomized traffic without halt.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'b0, $urandom_range(0, 3) == 0,
                $urandom, $urandom_range(0, 5) == 0, 26'($urandom), $urandom_range(0, 6) == 0, $urandom);
        // Halt together with an accept, then redirects must be ignored while halted.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        chk("halted_flag", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b0, 1'b0, 1'b1, $urandom, 1'b1, 26'($urandom), 1'b1, $urandom);
        // Reset out of HALTED, build a pending redirect, then reset asynchronously mid-cycle.
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("reset_halt");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h1234_5678);
        chk("pend_before_reset", {31'd0, redirect_pending}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);
        chk("after_reset_no_pending", pc, 32'h0040_0004);
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS datapath. It sits directly downstream of the branch-offset `shift_left_2` stage and consumes its word-aligned offset to form branch targets. It also forms jump and jump-register targets, holds the architectural PC, and issues fetch requests to instruction memory over a valid/ready handshake. A redirect that arrives while a fetch is stalled is buffered, never lost.

## Interface
Parameters:
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_ready` in 1: instruction memory accepts the current `pc`.
- `stall` in 1: hazard stall; blocks acceptance.
- `halt` in 1: enter HALTED (syscall/exit).
- `branch_taken` in 1: take branch this cycle.
- `branch_offset` in 32: shifted offset from `shift_left_2`.
- `jump` in 1: J/JAL redirect.
- `jump_index` in 26: instruction[25:0].
- `jr` in 1: JR redirect.
- `jr_target` in 32: register value.
- `pc` out 32: current fetch address.
- `pc_plus4` out 32: `pc` + 4, combinational.
- `fetch_valid` out 1: `pc` is a valid fetch request.
- `redirect_pending` out 1: buffered redirect is waiting.
- `halted` out 1: FSM is in HALTED.
- `misalign_err` out 1: sticky misaligned-target flag.

## Operation
- FSM states: BOOT, RUN, HALTED. Reset → BOOT; BOOT → RUN unconditionally after one cycle; RUN → HALTED when `halt`=1; HALTED is exited only by reset.
- `fetch_valid` = 1 only in RUN.
- accept = `fetch_valid` & `fetch_ready` & ~`stall`.
- Target formation, all 32-bit wrap-around arithmetic with no carry out:
  - base = `pc` register value.
  - branch = base + `branch_offset`.
  - jump = {base[31:28], `jump_index`, 2'b00}.
  - jr = `jr_target`.
- Priority when several requests are asserted: jr > jump > branch.
- Next PC on accept:
  - A live redirect this cycle, if any.
  - Otherwise the pending redirect, if any.
  - Otherwise `pc_plus4`.
  - The pending register clears on accept.
- A redirect without accept is written into the pending register. A newer redirect overwrites an older pending one.
- A redirect in BOOT or HALTED is ignored.
- `halt` and accept in the same cycle: the PC update happens, then the FSM goes to HALTED.

## Timing
- Reset values: `pc`=`RESET_PC`, `fetch_valid`=0, `redirect_pending`=0, `halted`=0, `misalign_err`=0, state BOOT.
- First `fetch_valid`=1 is in the 2nd cycle after `rst_n` deasserts.
- `pc` updates one cycle after accept (registered). No combinational path exists from any redirect input to `pc`.
- `redirect_pending` rises the cycle after an unaccepted redirect and falls the cycle after the next accept.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The pending redirect is discarded.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A selected target with bits[1:0] ≠ 0 is dropped; `pc` advances to `pc_plus4` instead.
  - `misalign_err` sets and stays set until reset.
- `PC_ALIGN_CHECK_EN` undefined:
  - Targets are used as-is, with low bits forced to 2'b00.
  - `misalign_err` is tied to 0.

## Test plan
- Reset then free run with `fetch_ready`=1: `pc` reads 0x00400000, then 0x00400004, then 0x00400008; `fetch_valid` first goes high in cycle 2.
- At `pc`=0x00400010, `branch_taken`=1 with `branch_offset`=0xFFFFFFF0 and an accept: next `pc`=0x00400000.
- `jump`=1 with `jump_index`=26'h0100020 while `fetch_ready`=0 for 3 cycles:
  - `redirect_pending`=1 and `pc` holds.
  - On accept, `pc`=0x00400080 and `redirect_pending`=0.
- `jr` and `branch_taken` both asserted, `jr_target`=0x00401000: next `pc`=0x00401000.
- `pc`=0xFFFFFFFC with an accept and no redirect: next `pc`=0x00000000 (wrap).
- With `PC_ALIGN_CHECK_EN` defined, `jr_target`=0x00400002: next `pc`=`pc_plus4` and `misalign_err`=1. Then assert `rst_n`=0 mid-run: all outputs return to reset values without a clock edge.
